// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared definitions for the dot-product accumulator.
//   PROD_W / PROD_MAX : width and largest legal value of a 4x3 product (15*7).
//   state_t           : frame FSM states (ACC = collecting terms, HOLD = sum presented).
//   dbg_t             : FSM observation struct (state + zero-extended term count).
//   cnt_width()       : term counter width for a given frame length.
package dot_acc_pkg;

  localparam int PROD_W   = 7;
  localparam int PROD_MAX = 105;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Counter is at most 8 bits (N_TERMS <= 256), so a fixed 8-bit field suffices.
  typedef struct packed {
    state_t     state;
    logic [7:0] cnt;
  } dbg_t;

  function automatic int cnt_width(input int n_terms);
    return $clog2(n_terms);
  endfunction

endpackage

// File: rtl/acc_add.sv
// acc_add: combinational accumulator adder, a + zero-extended b.
//   a   : current accumulator value (ACC_W bits)
//   b   : unsigned product (PROD_W bits)
//   sum : next accumulator value
//   carry (only with DOT_ACC_SAT_EN): the ACC_W+1-bit sum carried out
// Configuration macro DOT_ACC_SAT_EN:
//   defined   -> on carry out the sum saturates to all-ones
//   undefined -> the sum wraps modulo 2^ACC_W and no carry is produced
module acc_add
  import dot_acc_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum
`ifdef DOT_ACC_SAT_EN
  ,
  output logic              carry
`endif
);

`ifdef DOT_ACC_SAT_EN
  logic [ACC_W:0] raw;

  assign raw   = {1'b0, a} + (ACC_W+1)'(b);
  assign carry = raw[ACC_W];
  // Once saturated, adding any non-zero product carries again, so the
  // accumulator stays pinned at all-ones for the rest of the frame.
  assign sum   = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
`else
  assign sum = a + ACC_W'(b);
`endif

endmodule

// File: rtl/dot_acc_4x3.sv
// dot_acc_4x3: accumulates N_TERMS unsigned 7-bit products into one frame sum.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clear                : synchronous abort of the frame in progress (highest priority)
//   in_valid/in_ready    : product input handshake, in_prod is the product
//   out_valid/out_ready  : frame sum output handshake, out_sum/out_ovf are the result
//   busy                 : a term has been accepted this frame, or a result is held
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and the payload is stable while
// valid is high and ready is low.
// Configuration macro DOT_ACC_SAT_EN: when defined, a frame that carries out
// of ACC_W bits saturates to all-ones and reports out_ovf=1; when undefined
// the sum wraps and out_ovf is tied low.
module dot_acc_4x3
  import dot_acc_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int CNT_W = cnt_width(N_TERMS);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_nxt;
  logic             take;
  logic             last;
  dbg_t             dbg;

  assign take = in_valid & in_ready;
  assign last = (cnt == CNT_W'(N_TERMS - 1));

`ifdef DOT_ACC_SAT_EN
  logic carry;
  logic ovf_run;
  logic ovf_q;

  acc_add #(.ACC_W(ACC_W)) u_add (
    .a     (acc),
    .b     (in_prod),
    .sum   (sum_nxt),
    .carry (carry)
  );

  // ovf_run remembers any carry earlier in the frame; ovf_q is the reported flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_run <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      ovf_run <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (take) begin
      if (last) begin
        ovf_q   <= ovf_run | carry;
        ovf_run <= 1'b0;
      end else begin
        ovf_run <= ovf_run | carry;
      end
    end
  end

  assign out_ovf = ovf_q;
`else
  acc_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (in_prod),
    .sum (sum_nxt)
  );

  assign out_ovf = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (take && last) state_nxt = HOLD;
        HOLD:    if (out_ready)    state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC:     in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Accumulator, term counter and result register. out_sum is left alone by
  // clear so the last delivered sum stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      if (last) begin
        out_sum <= sum_nxt;
        acc     <= '0;
        cnt     <= '0;
      end else begin
        acc <= sum_nxt;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign dbg.state = state;
  assign dbg.cnt   = 8'(cnt);
  assign busy      = (dbg.cnt != 8'd0) | (dbg.state == HOLD);

  // Products come from a 4x3 multiplier and can never exceed 15*7.
  a_prod_range : assert property (@(posedge clk) disable iff (!rst_n)
    take |-> (in_prod <= 7'(PROD_MAX)));

endmodule

// File: tb/tb_dot_acc_4x3.sv
module tb_dot_acc_4x3;

  localparam int N_TERMS = 8;
  localparam int ACC_W   = 10;
  localparam int ACC_W7  = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (default widths) ----------------
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_prod = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  dot_acc_4x3 #(.N_TERMS(N_TERMS), .ACC_W(ACC_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  // ---------------- DUT (7-bit accumulator, overflow case) ----------------
  logic              in_valid_b = 1'b0;
  logic              in_ready_b;
  logic [6:0]        in_prod_b = 7'd100;
  logic              out_valid_b;
  logic [ACC_W7-1:0] out_sum_b;
  logic              out_ovf_b;
  logic              busy_b;

  dot_acc_4x3 #(.N_TERMS(N_TERMS), .ACC_W(ACC_W7)) u_dut_w7 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (1'b0),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_prod   (in_prod_b),
    .out_valid (out_valid_b),
    .out_ready (1'b1),
    .out_sum   (out_sum_b),
    .out_ovf   (out_ovf_b),
    .busy      (busy_b)
  );

  // ---------------- scoreboard state ----------------
  int             checks = 0;
  int             errors = 0;
  int             b_frames = 0;
  logic [ACC_W:0] exp_q[$];
  int             frame_terms[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame result from the plain arithmetic sum of its terms.
  // Returned as {ovf, sum} packed into an int (ovf at bit acc_w).
  function automatic int frame_expect(input int terms[$], input int acc_w);
    int total = 0;
    int lim   = 1 << acc_w;
    foreach (terms[i]) total += terms[i];
`ifdef DOT_ACC_SAT_EN
    if (total >= lim) return lim | (lim - 1);
    return total;
`else
    return total % lim;
`endif
  endfunction

  // Model reaction to one accepted term (clear in the same cycle aborts the frame).
  task automatic model_accept(input int p, input bit with_clear);
    if (with_clear) begin
      frame_terms.delete();
      return;
    end
    frame_terms.push_back(p);
    if (frame_terms.size() == N_TERMS) begin
      exp_q.push_back((ACC_W+1)'(frame_expect(frame_terms, ACC_W)));
      frame_terms.delete();
    end
  endtask

  // ---------------- driver tasks (enter and leave on a falling edge) ----------------
  task automatic send_term(input int p, input bit with_clear);
    int budget = 0;
    in_valid = 1'b1;
    in_prod  = 7'(p);
    clear    = with_clear;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      model_accept(p, with_clear);
    end
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic gap(input int max_cycles);
    repeat ($urandom_range(0, max_cycles)) @(negedge clk);
  endtask

  task automatic random_frame(input int max_gap);
    for (int i = 0; i < N_TERMS; i++) begin
      send_term($urandom_range(0, 105), 1'b0);
      gap(max_gap);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin
    logic [ACC_W:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'({out_ovf, out_sum}), 32'hFFFF);
        end else begin
          exp = exp_q.pop_front();
          check("frame_result", 32'({out_ovf, out_sum}), 32'(exp));
        end
      end
    end
  end

  initial begin
    int b_terms[$];
    int b_exp;
    for (int i = 0; i < N_TERMS; i++) b_terms.push_back(100);
    b_exp = frame_expect(b_terms, ACC_W7);
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid_b) begin
        check("w7_frame", 32'({out_ovf_b, out_sum_b}), 32'(b_exp));
        b_frames++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [ACC_W-1:0] held;
    int budget;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid_b = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // 1: 1..8 back-to-back
    out_ready = 1'b1;
    for (int p = 1; p <= 8; p++) send_term(p, 1'b0);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_in_ready",  32'(in_ready),  32'd0);
    check("t1_out_sum",   32'(out_sum),   32'd36);
    check("t1_out_ovf",   32'(out_ovf),   32'd0);

    // 2: eight 105s with random gaps
    for (int i = 0; i < N_TERMS; i++) begin
      send_term(105, 1'b0);
      check("t2_busy", 32'(busy), 32'd1);
      if (i != N_TERMS - 1) gap(3);
    end
    check("t2_out_sum", 32'(out_sum), 32'd840);
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_valid_after", 32'(out_valid), 32'd0);

    // 3: backpressure, inputs offered during HOLD must be ignored
    out_ready = 1'b0;
    for (int i = 0; i < N_TERMS; i++) send_term($urandom_range(1, 105), 1'b0);
    held = out_sum;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_prod  = 7'd50;
      check("t3_out_valid", 32'(out_valid), 32'd1);
      check("t3_in_ready",  32'(in_ready),  32'd0);
      check("t3_sum_stable", 32'(out_sum),  32'(held));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    random_frame(2);

    // random frames with random output backpressure
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N_TERMS; i++) begin
        out_ready = 1'($urandom_range(0, 1));
        send_term($urandom_range(0, 105), 1'b0);
        gap(2);
      end
      gap(3);
      out_ready = 1'b1;
      @(negedge clk);
    end

    // 5: clear together with the 8th handshake
    for (int i = 0; i < N_TERMS - 1; i++) send_term(1, 1'b0);
    send_term(1, 1'b1);
    check("t5_no_valid", 32'(out_valid), 32'd0);
    check("t5_busy",     32'(busy),      32'd0);
    for (int i = 0; i < N_TERMS; i++) send_term(1, 1'b0);
    check("t5_out_sum", 32'(out_sum), 32'd8);

    // 6: asynchronous reset mid-frame
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_term($urandom_range(1, 105), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_sum",   32'(out_sum),   32'd0);
    check("t6_out_ovf",   32'(out_ovf),   32'd0);
    check("t6_busy",      32'(busy),      32'd0);
    frame_terms.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    random_frame(1);

    // drain
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("w7_frames_seen", 32'(b_frames > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_acc_4x3.md
Name: dot_acc_4x3

Overview:
Downstream consumer of the 4x3 unsigned array multiplier. Accepts a stream of 7-bit products over a valid/ready handshake and accumulates exactly N_TERMS of them into one dot-product frame. Presents the frame sum on an output valid/ready handshake. Forms the accumulate stage of the small fixed-point MAC datapath.

Parameters:
N_TERMS, 8, number of products per frame; legal range 2..256.
ACC_W, 10, accumulator and out_sum width; must be >= 7. The default holds 8*105 = 840 without overflow.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; drops the frame in progress
in_valid  input  1  in_prod is valid
in_ready  output  1  block accepts in_prod this cycle
in_prod  input  7  unsigned product from multiplier, 0..105
out_valid  output  1  out_sum holds a completed frame
out_ready  input  1  consumer takes out_sum
out_sum  output  ACC_W  frame sum
out_ovf  output  1  frame overflowed ACC_W (see Optional Feature)
busy  output  1  at least one term accepted in the current frame, or frame held

Behaviour:
- Reset (rst_n low, asynchronous) and reset values:
  - Next state ACC; acc=0; cnt=0.
  - out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - in_ready=1 once rst_n is released.
- Accepted term: handshake = in_valid & in_ready.
- State ACC:
  - in_ready=1, out_valid=0.
  - On handshake with cnt < N_TERMS-1: acc <= acc + zero-extended in_prod; cnt <= cnt+1.
  - On handshake with cnt == N_TERMS-1: out_sum <= acc + in_prod; out_ovf updated; acc <= 0; cnt <= 0; go to HOLD.
- State HOLD:
  - in_ready=0; out_valid=1.
  - out_sum and out_ovf are stable while out_valid & !out_ready.
  - On out_ready: go to ACC; out_valid drops next cycle.
- Timing:
  - Latency: out_valid rises on the clock edge after the last term's handshake.
  - Throughput: one frame per N_TERMS+1 cycles minimum.
  - No overlap: no input is accepted in the HOLD cycle, even when out_ready is high.
- in_valid low in ACC: acc and cnt hold.
- Bubbles between terms are allowed.
- clear:
  - Takes priority over every other event, including a simultaneous last-term handshake or out_ready.
  - Next cycle: ACC, acc=0, cnt=0, out_valid=0, out_ovf=0.
  - out_sum keeps its last value.
- busy = (cnt != 0) | (state == HOLD).
- Arithmetic:
  - Unsigned throughout.
  - Internal sum is ACC_W+1 bits; the extra MSB is the carry used for overflow detection.
  - out_ovf is sticky within a frame: set if any addition in the frame carried out.
- Reset mid-frame: partial sum is discarded with no output.

Optional Feature:
Macro DOT_ACC_SAT_EN.
- Defined:
  - On carry out, acc saturates to all-ones and stays there for the rest of the frame.
  - out_sum = 2^ACC_W-1 and out_ovf=1 for that frame.
- Undefined:
  - Sum wraps modulo 2^ACC_W.
  - out_ovf is tied 0; the overflow-tracking flop is not built.

Decomposition:
- Package dot_acc_pkg holds:
  - localparam PROD_W = 7 and PROD_MAX = 105.
  - State enum: ACC, HOLD.
  - Function computing CNT_W = $clog2(N_TERMS).
- One natural sub-module, acc_add:
  - Combinational ACC_W-bit adder with carry out and optional saturation (same macro).
  - Keeps the FSM/counter logic in the top module separate.

Test Plan:
1. Defaults; products 1,2,3,4,5,6,7,8 back-to-back, out_ready=1 -> out_valid one cycle after 8th handshake; out_sum=36; out_ovf=0; in_ready low that cycle.
2. Eight products of 105 with random in_valid gaps -> out_sum=840, no overflow; busy high from first accept until the HOLD handshake.
3. Backpressure: out_ready=0 for 5 cycles after frame done -> out_valid/out_sum stable; in_ready=0; in_valid ignored; release -> next frame starts clean from 0.
4. ACC_W=7, products 100,100,... -> with DOT_ACC_SAT_EN: out_sum=127, out_ovf=1. Without: out_sum=(sum mod 128), out_ovf=0.
5. clear asserted together with the 8th handshake -> no out_valid; next frame of eight 1s gives out_sum=8.
6. rst_n pulsed low asynchronously mid-frame (after 3 terms) -> outputs zero immediately; subsequent full frame sums correctly.
